// File: rtl/pipe_hazard_ctrl_if.sv
//============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Hazard-control bus; stall_cnt/flush_cnt exist only with HAZ_PERF_CNT_EN.
// Revision : 1.0
//============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_memread;
    logic        ex_regwrite;
    logic [2:0]  ex_rd;
    logic        branch_taken;
    logic        mem_busy;
    logic        pc_en;
    logic        ifid_en;
    logic        pipe_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        init_busy;
    logic        mem_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    modport slave (
`ifdef HAZ_PERF_CNT_EN
        output stall_cnt, flush_cnt,
`endif
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  ex_memread, ex_regwrite, ex_rd, branch_taken, mem_busy,
        output pc_en, ifid_en, pipe_en, ifid_flush, idex_flush,
        output init_busy, mem_timeout
    );

    modport master (
`ifdef HAZ_PERF_CNT_EN
        input  stall_cnt, flush_cnt,
`endif
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output ex_memread, ex_regwrite, ex_rd, branch_taken, mem_busy,
        input  pc_en, ifid_en, pipe_en, ifid_flush, idex_flush,
        input  init_busy, mem_timeout
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Pipeline stall/flush/freeze controller; HAZ_PERF_CNT_EN adds perf counters.
// Revision : 1.0
//============================================================================
`default_nettype none

module pipe_hazard_ctrl (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] C_DRAIN_LAST = 2'd3;
    localparam logic [7:0] C_WAIT_MAX   = 8'hFF;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_drain;
    logic [7:0] r_wait_cnt;
    logic       r_mem_timeout;
    logic       w_load_use;
    logic       w_init;
    logic       w_freeze;
    logic       w_run_dec;

    assign w_load_use = hz.ex_memread & hz.ex_regwrite &
                        ((hz.id_uses_rs & (hz.id_rs == hz.ex_rd)) |
                         (hz.id_uses_rt & (hz.id_rt == hz.ex_rd)));

    always_comb begin
        w_state_nxt   = r_state;
        w_init        = 1'b0;
        w_freeze      = 1'b0;
        w_run_dec     = 1'b0;
        hz.pc_en      = 1'b1;
        hz.ifid_en    = 1'b1;
        hz.pipe_en    = 1'b1;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;
        hz.init_busy  = 1'b0;

        case (r_state)
            S_INIT: begin
                w_init = 1'b1;
                if (r_drain == C_DRAIN_LAST)
                    w_state_nxt = S_RUN;
            end
            // MEM_WAIT only differs from RUN in where it came from; the decode is shared.
            S_RUN, S_MEM_WAIT: begin
                if (hz.mem_busy) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = S_MEM_WAIT;
                end else begin
                    w_run_dec   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_init      = 1'b1;
                w_state_nxt = S_INIT;
            end
        endcase

        if (rst || w_init) begin
            hz.pc_en      = 1'b0;
            hz.ifid_en    = 1'b0;
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
            hz.init_busy  = 1'b1;
        end else if (w_freeze) begin
            hz.pc_en      = 1'b0;
            hz.ifid_en    = 1'b0;
            hz.pipe_en    = 1'b0;
        end else if (hz.branch_taken) begin
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else if (w_load_use) begin
            hz.pc_en      = 1'b0;
            hz.ifid_en    = 1'b0;
            hz.idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_INIT;
            r_drain       <= 2'd0;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= (r_state == S_INIT) ? r_drain + 2'd1 : 2'd0;
            if (w_freeze) begin
                if (r_wait_cnt != C_WAIT_MAX)
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                else
                    r_mem_timeout <= 1'b1;
            end else if (w_run_dec) begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

    // Gate with rst so outputs hold reset values even before the first edge.
    assign hz.mem_timeout = r_mem_timeout & ~rst;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_evt;

    assign w_flush_evt = w_run_dec & hz.branch_taken;
    assign w_stall_evt = w_freeze | (w_run_dec & ~hz.branch_taken & w_load_use);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != C_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush_evt && (r_flush_cnt != C_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign hz.stall_cnt = rst ? 16'd0 : r_stall_cnt;
    assign hz.flush_cnt = rst ? 16'd0 : r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed + random bench for pipe_hazard_ctrl against a rule-level model.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycles of drain left, length of the current freeze run,
    // sticky timeout and event counters.
    int m_init_left  = 4;
    int m_freeze_run = 0;
    bit m_timeout    = 1'b0;
    int m_stall      = 0;
    int m_flush      = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic mb, input logic br, input logic mr, input logic rw,
                          input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                          input logic urs, input logic urt);
        bus.mem_busy     = mb;
        bus.branch_taken = br;
        bus.ex_memread   = mr;
        bus.ex_regwrite  = rw;
        bus.ex_rd        = rd;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_uses_rs   = urs;
        bus.id_uses_rt   = urt;
    endtask

    // One clock: check outputs at negedge against the model, then advance the model.
    task automatic cycle();
        bit ini, lu;
        bit e_pc, e_ifid, e_pipe, e_iff, e_idf, e_busy;
        @(negedge clk);
        ini = rst || (m_init_left > 0);
        lu  = bus.ex_memread && bus.ex_regwrite &&
              ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
               (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
        e_pc = 1; e_ifid = 1; e_pipe = 1; e_iff = 0; e_idf = 0; e_busy = 0;
        if (ini) begin
            e_pc = 0; e_ifid = 0; e_iff = 1; e_idf = 1; e_busy = 1;
        end else if (bus.mem_busy) begin
            e_pc = 0; e_ifid = 0; e_pipe = 0;
        end else if (bus.branch_taken) begin
            e_iff = 1; e_idf = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_idf = 1;
        end
        chk("pc_en",       16'(bus.pc_en),       16'(e_pc));
        chk("ifid_en",     16'(bus.ifid_en),     16'(e_ifid));
        chk("pipe_en",     16'(bus.pipe_en),     16'(e_pipe));
        chk("ifid_flush",  16'(bus.ifid_flush),  16'(e_iff));
        chk("idex_flush",  16'(bus.idex_flush),  16'(e_idf));
        chk("init_busy",   16'(bus.init_busy),   16'(e_busy));
        chk("mem_timeout", 16'(bus.mem_timeout), 16'(m_timeout && !rst));
`ifdef HAZ_PERF_CNT_EN
        chk("stall_cnt", bus.stall_cnt, rst ? 16'd0 : 16'(m_stall));
        chk("flush_cnt", bus.flush_cnt, rst ? 16'd0 : 16'(m_flush));
`endif
        @(posedge clk);
        if (rst) begin
            m_init_left = 4; m_freeze_run = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else if (bus.mem_busy) begin
            m_freeze_run++;
            if (m_freeze_run >= 256) m_timeout = 1;
            if (m_stall < 65535) m_stall++;
        end else begin
            m_freeze_run = 0;
            if (bus.branch_taken) begin
                if (m_flush < 65535) m_flush++;
            end else if (lu) begin
                if (m_stall < 65535) m_stall++;
            end
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_in(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (6) cycle();                          // 4 drain cycles, then normal

        set_in(0, 0, 1, 1, 3'd3, 3'd3, 3'd5, 1, 0);  // load-use on rs
        cycle();
        set_in(0, 1, 1, 1, 3'd3, 3'd3, 3'd5, 1, 0);  // branch beats load-use
        cycle();
        set_in(0, 0, 1, 1, 3'd0, 3'd4, 3'd0, 0, 1);  // register 0 hazards too
        cycle();
        set_in(0, 0, 1, 0, 3'd2, 3'd2, 3'd2, 1, 1);  // no regwrite: no hazard
        cycle();

        set_in(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        repeat (3) cycle();
        set_in(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        cycle();
        chk("timeout_after_3", 16'(bus.mem_timeout), 16'd0);

        set_in(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        repeat (255) cycle();
        chk("timeout_before_256", 16'(bus.mem_timeout), 16'd0);
        cycle();
        chk("timeout_at_257", 16'(bus.mem_timeout), 16'd1);
        set_in(0, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);
        repeat (3) cycle();
        chk("timeout_sticky", 16'(bus.mem_timeout), 16'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("timeout_cleared", 16'(bus.mem_timeout), 16'd0);
        repeat (5) cycle();

        set_in(1, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0);  // reset in the middle of MEM_WAIT
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (4) cycle();
        set_in(0, 0, 1, 1, 3'd1, 3'd1, 3'd1, 1, 1);
        repeat (2) cycle();

        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                   1'($urandom), 1'($urandom),
                   3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom));
            rst = ($urandom_range(0, 249) == 0);
            cycle();
        end
        rst = 1'b0;
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
